// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon32/64 key schedule and round datapath.
package simon_pkg;

    localparam logic [61:0] SIMON_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [15:0] SIMON_C  = 16'hFFFC;

    typedef logic [15:0] simon_word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } simon_ks_state_t;

    // Element 0 of the z0 sequence is the MSB; indices past 61 never feed a used key.
    function automatic logic z0_bit(input logic [5:0] i);
        return (i > 6'd61) ? 1'b0 : SIMON_Z0[6'd61 - i];
    endfunction

endpackage

// File: rtl/simon_ks_step.sv
// One Simon32/64 key-schedule step: knew from k[i], k[i+1], k[i+3] and the z0 bit.
// k[i+2] does not contribute for the four-word (m=4) schedule, so it is not a port.
module simon_ks_step
    import simon_pkg::*;
(
    input  simon_word_t k0,
    input  simon_word_t k1,
    input  simon_word_t k3,
    input  logic        z,
    output simon_word_t knew
);

    simon_word_t tmp_a;
    simon_word_t tmp_b;

    assign tmp_a = {k3[2:0], k3[15:3]} ^ k1;
    assign tmp_b = tmp_a ^ {tmp_a[0], tmp_a[15:1]};
    assign knew  = ~k0 ^ tmp_b ^ {15'd0, z} ^ 16'h0003;

endmodule

// File: rtl/simon_key_expand.sv
// Simon32/64 key schedule streaming one round key per accepted handshake.
// Build option SIMON_KS_ZEROIZE_EN: wipe key registers when the block completes.
module simon_key_expand
    import simon_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ROUNDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       key_in,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [WORD_W-1:0] rk,
    output logic [4:0]        rk_idx,
    output logic              rk_last,
    output logic              done
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

`ifdef SIMON_KS_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    simon_ks_state_t state_reg;
    simon_ks_state_t state_next;
    simon_word_t     kreg_reg [4];
    simon_word_t     shift_in [4];
    logic [5:0]      idx_reg;
    simon_word_t     knew;
    logic            in_run;
    logic            load;
    logic            accept;
    logic            last;
    logic            wipe;

    assign in_run = (state_reg == RUN);
    assign load   = (state_reg == IDLE) && start;
    assign accept = in_run && rk_ready;
    assign last   = in_run && (idx_reg == LAST_IDX);
    assign wipe   = ZEROIZE && accept && last;

    simon_ks_step u_step (
        .k0   (kreg_reg[0]),
        .k1   (kreg_reg[1]),
        .k3   (kreg_reg[3]),
        .z    (z0_bit(idx_reg)),
        .knew (knew)
    );

    // Word w takes word w+1 on each accepted key; the top word takes the fresh key.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift
            if (gi < 3) begin : g_mid
                assign shift_in[gi] = kreg_reg[gi+1];
            end else begin : g_top
                assign shift_in[gi] = knew;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 4; w++) kreg_reg[w] <= '0;
        end else if (load) begin
            for (int w = 0; w < 4; w++) kreg_reg[w] <= key_in[16*w +: 16];
        end else if (wipe) begin
            for (int w = 0; w < 4; w++) kreg_reg[w] <= '0;
        end else if (accept) begin
            for (int w = 0; w < 4; w++) kreg_reg[w] <= shift_in[w];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (load) begin
            idx_reg <= '0;
        end else if (accept) begin
            idx_reg <= idx_reg + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        rk_valid   = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                if (accept && last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rk      = kreg_reg[0];
    assign rk_idx  = idx_reg[4:0];
    assign rk_last = last;

endmodule

// File: tb/tb_simon_key_expand.sv
// Directed bench for simon_key_expand: reset, streaming, backpressure, ignored start, mid-run reset.
module tb_simon_key_expand;

    localparam int ROUNDS = 32;
    localparam logic [63:0] KEY   = 64'h1918_1110_0908_0100;
    localparam logic [63:0] OTHER = 64'hA5A5_5A5A_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] key_in = '0;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready = 1'b0;
    logic [15:0] rk;
    logic [4:0]  rk_idx;
    logic        rk_last;
    logic        done;

    int errors = 0;
    int checks = 0;

    simon_key_expand #(.WORD_W(16), .ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] rk;
    } kv_t;

    typedef struct {
        string name;
        bit    toggle;
        int    start_at;
        int    rst_at;
        int    cycles;
    } scen_t;

    kv_t         kv [5];
    scen_t       scen [5];
    logic [15:0] mk [ROUNDS+1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] x, input int r);
        return (x >> r) | (x << (16 - r));
    endfunction

    // Reference key schedule in the textbook form k[i+4] = c ^ k[i] ^ z ^ f(k[i+1], k[i+3]).
    task automatic build_model(input logic [63:0] key);
        logic [61:0] z;
        logic [15:0] t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int w = 0; w < 4; w++) mk[w] = key[16*w +: 16];
        for (int i = 0; i + 4 <= ROUNDS; i++) begin
            t = ror16(mk[i+3], 3) ^ mk[i+1];
            t = t ^ ror16(t, 1);
            mk[i+4] = 16'hFFFC ^ mk[i] ^ t ^ {15'd0, z[61-i]};
        end
    endtask

    function automatic logic [15:0] exp_rk(input int i);
        return (i < 5) ? kv[i].rk : mk[i];
    endfunction

    task automatic run_block(input scen_t sc);
        int  i;
        int  cyc;
        bit  accepted;
        bit  pulsed;
        i = 0;
        cyc = 0;
        pulsed = 1'b0;
        key_in = KEY;
        start = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key_in = OTHER;
        while (i < ROUNDS && cyc < 200) begin
            check({sc.name, " rk_valid"}, 64'(rk_valid), 64'd1);
            check({sc.name, " busy"}, 64'(busy), 64'd1);
            check({sc.name, " rk"}, 64'(rk), 64'(exp_rk(i)));
            check({sc.name, " rk_idx"}, 64'(rk_idx), 64'(i[4:0]));
            check({sc.name, " rk_last"}, 64'(rk_last), 64'(i == ROUNDS - 1));
            check({sc.name, " done_low"}, 64'(done), 64'd0);
            if (sc.rst_at == i) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check({sc.name, " rst rk_valid"}, 64'(rk_valid), 64'd0);
                check({sc.name, " rst busy"}, 64'(busy), 64'd0);
                check({sc.name, " rst rk_idx"}, 64'(rk_idx), 64'd0);
                check({sc.name, " rst rk"}, 64'(rk), 64'd0);
                for (int k = 0; k < 3; k++) begin
                    check({sc.name, " rst no done"}, 64'(done), 64'd0);
                    @(posedge clk); #1;
                end
                $display("%s: reset at i=%0d", sc.name, i);
                return;
            end
            if (sc.start_at == i && !pulsed) begin
                start = 1'b1;
                key_in = OTHER ^ 64'hFFFF;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            rk_ready = sc.toggle ? (cyc % 2 == 0) : 1'b1;
            accepted = rk_ready;
            @(posedge clk); #1;
            if (accepted) begin
                $display("%s: key i=%0d rk=%04h", sc.name, i, exp_rk(i));
                i++;
            end
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 200) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: got %0d keys, expected %0d", sc.name, i, ROUNDS);
            return;
        end
        check({sc.name, " done_cycle"}, 64'(cyc), 64'(sc.cycles));
        check({sc.name, " done"}, 64'(done), 64'd1);
        check({sc.name, " done busy"}, 64'(busy), 64'd0);
        check({sc.name, " done rk_valid"}, 64'(rk_valid), 64'd0);
`ifdef SIMON_KS_ZEROIZE_EN
        check({sc.name, " residue rk"}, 64'(rk), 64'd0);
`else
        check({sc.name, " residue rk"}, 64'(rk), 64'(mk[ROUNDS]));
`endif
        // start during DONE must not launch a new block
        start = 1'b1;
        key_in = KEY;
        @(posedge clk); #1;
        start = 1'b0;
        check({sc.name, " post done"}, 64'(done), 64'd0);
        check({sc.name, " start in DONE ignored"}, 64'(busy), 64'd0);
        $display("%s: block complete after %0d cycles", sc.name, cyc);
        @(posedge clk); #1;
    endtask

    initial begin
        kv[0] = '{0, 16'h0100};
        kv[1] = '{1, 16'h0908};
        kv[2] = '{2, 16'h1110};
        kv[3] = '{3, 16'h1918};
        kv[4] = '{4, 16'h71C3};
        scen[0] = '{"plain",    1'b0, -1, -1, ROUNDS};
        scen[1] = '{"toggle",   1'b1, -1, -1, 2*ROUNDS - 1};
        scen[2] = '{"start_mid", 1'b0, 10, -1, ROUNDS};
        scen[3] = '{"rst_mid",  1'b0, -1,  7, ROUNDS};
        scen[4] = '{"restart",  1'b0, -1, -1, ROUNDS};
        build_model(KEY);

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset rk_valid", 64'(rk_valid), 64'd0);
        check("reset rk_last", 64'(rk_last), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rk", 64'(rk), 64'd0);
        check("reset rk_idx", 64'(rk_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy", 64'(busy), 64'd0);
        $display("reset: outputs idle");

        for (int s = 0; s < 5; s++) begin
            run_block(scen[s]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
